// File: rtl/axi_lite_cmd_master.sv
`default_nettype none
// ==========================================================================
// axi_lite_cmd_master : queued AXI-Lite master; read/write commands are
// buffered in a FIFO, executed one at a time, each returning a response.
// Revision 1.0
// ==========================================================================
module axi_lite_cmd_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic                   CMD_VALID,
  output logic                   CMD_READY,
  input  logic                   CMD_WRITE,
  input  logic [ADDR_W-1:0]      CMD_ADDR,
  input  logic [DATA_W-1:0]      CMD_WDATA,
  input  logic [DATA_W/8-1:0]    CMD_WSTRB,
  output logic [$clog2(DEPTH):0] CMD_LEVEL,
  output logic                   RSP_VALID,
  input  logic                   RSP_READY,
  output logic                   RSP_WRITE,
  output logic [DATA_W-1:0]      RSP_DATA,
  output logic [2:0]             RSP_STATUS,
  output logic                   BUSY,
  output logic                   AWVALID,
  input  logic                   AWREADY,
  output logic [ADDR_W-1:0]      AWADDR,
  output logic                   WVALID,
  input  logic                   WREADY,
  output logic [DATA_W-1:0]      WDATA,
  output logic [DATA_W/8-1:0]    WSTRB,
  input  logic                   BVALID,
  output logic                   BREADY,
  input  logic [1:0]             BRESP,
  output logic                   ARVALID,
  input  logic                   ARREADY,
  output logic [ADDR_W-1:0]      ARADDR,
  input  logic                   RVALID,
  output logic                   RREADY,
  input  logic [DATA_W-1:0]      RDATA,
  input  logic [1:0]             RRESP
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit               TO_EN    = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_WB   = 3'd2,
    S_RA   = 3'd3,
    S_RD   = 3'd4,
    S_RSP  = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic              fifo_write [DEPTH];
  logic [ADDR_W-1:0] fifo_addr  [DEPTH];
  logic [DATA_W-1:0] fifo_wdata [DEPTH];
  logic [STRB_W-1:0] fifo_wstrb [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              push, pop;

  logic              loaded;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_wstrb;

  logic              aw_done, w_done;
  logic [CNT_W-1:0]  wait_cnt;
  logic              to_hit;
  logic              capture;
  logic              cap_write;
  logic [DATA_W-1:0] cap_data;
  logic [2:0]        cap_status;

  assign CMD_READY = (level != FULL_LVL);
  assign CMD_LEVEL = level;
  assign push      = CMD_VALID && CMD_READY;
  // The pop only happens when no popped command is waiting, which yields the IDLE gap.
  assign pop       = (state_q == S_IDLE) && !loaded && (level != '0);
  assign BUSY      = (state_q != S_IDLE) || (level != '0) || loaded;
  assign to_hit    = TO_EN && (wait_cnt == CNT_LAST);

  assign AWADDR = cmd_addr;
  assign ARADDR = cmd_addr;
  assign WDATA  = cmd_wdata;
  assign WSTRB  = cmd_wstrb;

  always_ff @(posedge ACLK) begin
    if (push) begin
      fifo_write[wr_ptr] <= CMD_WRITE;
      fifo_addr[wr_ptr]  <= CMD_ADDR;
      fifo_wdata[wr_ptr] <= CMD_WDATA;
      fifo_wstrb[wr_ptr] <= CMD_WSTRB;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      loaded    <= 1'b0;
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_wstrb <= '0;
    end else begin
      loaded <= pop;
      if (pop) begin
        cmd_write <= fifo_write[rd_ptr];
        cmd_addr  <= fifo_addr[rd_ptr];
        cmd_wdata <= fifo_wdata[rd_ptr];
        cmd_wstrb <= fifo_wstrb[rd_ptr];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    cap_write  = cmd_write;
    cap_data   = '0;
    cap_status = 3'b000;
    AWVALID    = 1'b0;
    WVALID     = 1'b0;
    BREADY     = 1'b0;
    ARVALID    = 1'b0;
    RREADY     = 1'b0;
    RSP_VALID  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (loaded) state_d = cmd_write ? S_WR : S_RA;
      end
      S_WR: begin
        AWVALID = !aw_done;
        WVALID  = !w_done;
        if ((aw_done || AWREADY) && (w_done || WREADY)) begin
          state_d = S_WB;
        end else if (to_hit) begin
          state_d    = S_RSP;
          capture    = 1'b1;
          cap_status = 3'b100;
        end
      end
      S_WB: begin
        BREADY = 1'b1;
        if (BVALID) begin
          state_d    = S_RSP;
          capture    = 1'b1;
          cap_status = {1'b0, BRESP};
        end else if (to_hit) begin
          state_d    = S_RSP;
          capture    = 1'b1;
          cap_status = 3'b100;
        end
      end
      S_RA: begin
        ARVALID = 1'b1;
        if (ARREADY) begin
          state_d = S_RD;
        end else if (to_hit) begin
          state_d    = S_RSP;
          capture    = 1'b1;
          cap_status = 3'b100;
        end
      end
      S_RD: begin
        RREADY = 1'b1;
        if (RVALID) begin
          state_d    = S_RSP;
          capture    = 1'b1;
          cap_data   = RDATA;
          cap_status = {1'b0, RRESP};
        end else if (to_hit) begin
          state_d    = S_RSP;
          capture    = 1'b1;
          cap_status = 3'b100;
        end
      end
      S_RSP: begin
        RSP_VALID = 1'b1;
        if (RSP_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= S_IDLE;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      wait_cnt   <= '0;
      RSP_WRITE  <= 1'b0;
      RSP_DATA   <= '0;
      RSP_STATUS <= 3'b000;
    end else begin
      state_q <= state_d;
      if (state_q != S_WR) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (AWVALID && AWREADY) aw_done <= 1'b1;
        if (WVALID && WREADY)   w_done  <= 1'b1;
      end
      // The wait budget restarts on every state change so each wait state gets its own window.
      if (state_d != state_q)
        wait_cnt <= '0;
      else if (state_q inside {S_WR, S_WB, S_RA, S_RD})
        wait_cnt <= wait_cnt + CNT_W'(1);
      if (capture) begin
        RSP_WRITE  <= cap_write;
        RSP_DATA   <= cap_data;
        RSP_STATUS <= cap_status;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_cmd_master.sv
`default_nettype none
// ==========================================================================
// tb_axi_lite_cmd_master : scoreboard bench with a behavioural AXI-Lite slave.
// Revision 1.0
// ==========================================================================
`timescale 1ns/1ps
module tb_axi_lite_cmd_master;

  logic        ACLK;
  logic        ARESET;
  logic        CMD_VALID, CMD_READY, CMD_WRITE;
  logic [31:0] CMD_ADDR, CMD_WDATA;
  logic [3:0]  CMD_WSTRB;
  logic [2:0]  CMD_LEVEL;
  logic        RSP_VALID, RSP_READY, RSP_WRITE;
  logic [31:0] RSP_DATA;
  logic [2:0]  RSP_STATUS;
  logic        BUSY;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;

  axi_lite_cmd_master #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .TIMEOUT(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_WSTRB(CMD_WSTRB),
    .CMD_LEVEL(CMD_LEVEL),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_WRITE(RSP_WRITE),
    .RSP_DATA(RSP_DATA), .RSP_STATUS(RSP_STATUS), .BUSY(BUSY),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct packed {logic wr; logic [31:0] data; logic [2:0] status;} rsp_t;
  typedef struct packed {logic [31:0] addr; logic [31:0] data; logic [3:0] strb;} wr_t;
  rsp_t sb[$];
  wr_t  wq[$];

  int n_cmp = 0, n_err = 0;
  int aw_cycles = 0, w_cycles = 0, ar_cycles = 0, b_hs = 0, aw_hs = 0;
  int rsp_valid_cycles = 0;
  int aw_lat = 0, w_lat = 0;
  logic stall = 0, ar_stall = 0, r_hold = 0;

  function automatic logic [1:0] resp_fn(input logic [31:0] a);
    return a[5:4];
  endfunction

  function automatic logic [31:0] rdata_fn(input logic [31:0] a);
    return (a == 32'hFFFF_0004) ? 32'h0000_00A5 : (a ^ 32'hC3C3_5A5A);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic exp_to);
    int   t = 0;
    rsp_t e;
    wr_t  w;
    CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = a; CMD_WDATA = d; CMD_WSTRB = s;
    while (!CMD_READY && t < 200) begin @(negedge ACLK); t++; end
    if (!CMD_READY) begin
      check("push_accept", 0, 1);
    end else begin
      @(posedge ACLK);
      e.wr     = wr;
      e.data   = (wr || exp_to) ? 32'h0 : rdata_fn(a);
      e.status = exp_to ? 3'b100 : {1'b0, resp_fn(a)};
      sb.push_back(e);
      if (wr && !exp_to) begin
        w.addr = a; w.data = d; w.strb = s;
        wq.push_back(w);
      end
    end
    @(negedge ACLK);
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while ((sb.size() != 0 || BUSY) && t < 500) begin @(negedge ACLK); t++; end
    check(tag, {63'd0, (sb.size() == 0 && !BUSY)}, 1);
  endtask

  // Behavioural slave: decides READY/VALID at each negedge.
  initial begin
    int          aw_wait = 0, w_wait = 0;
    logic        aw_got = 0, w_got = 0, ar_got = 0, b_pend = 0, r_pend = 0;
    logic [31:0] aw_addr_l = 0, w_data_l = 0, ar_addr_l = 0;
    logic [3:0]  w_strb_l = 0;
    wr_t         wb;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
    ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_pend = 0; r_pend = 0;
        aw_wait = 0; w_wait = 0;
      end else begin
        if (b_pend) begin BVALID = 0; b_pend = 0; end
        if (r_pend) begin RVALID = 0; r_pend = 0; end
        if (aw_got && w_got && !BVALID) begin
          BVALID = 1; BRESP = resp_fn(aw_addr_l); aw_got = 0; w_got = 0;
          if (wq.size() == 0) check("wr_unexpected", 1, 0);
          else begin
            wb = wq.pop_front();
            check("awaddr", aw_addr_l, wb.addr);
            check("wdata", w_data_l, wb.data);
            check("wstrb", w_strb_l, wb.strb);
          end
        end
        if (ar_got && !RVALID && !r_hold) begin
          RVALID = 1; RDATA = rdata_fn(ar_addr_l); RRESP = resp_fn(ar_addr_l); ar_got = 0;
        end
        AWREADY = AWVALID && !stall && (aw_wait >= aw_lat);
        WREADY  = WVALID && !stall && (w_wait >= w_lat);
        ARREADY = ARVALID && !stall && !ar_stall;
        aw_wait = AWVALID ? aw_wait + 1 : 0;
        w_wait  = WVALID ? w_wait + 1 : 0;
        if (AWVALID && AWREADY) begin aw_got = 1; aw_addr_l = AWADDR; aw_hs++; end
        if (WVALID && WREADY) begin w_got = 1; w_data_l = WDATA; w_strb_l = WSTRB; end
        if (ARVALID && ARREADY) begin ar_got = 1; ar_addr_l = ARADDR; end
        if (BVALID && BREADY) begin b_pend = 1; b_hs++; end
        if (RVALID && RREADY) r_pend = 1;
        if (AWVALID) aw_cycles++;
        if (WVALID)  w_cycles++;
        if (ARVALID) ar_cycles++;
      end
    end
  end

  // Response monitor: scoreboard pop on each RSP handshake.
  initial begin
    rsp_t e;
    forever begin
      @(negedge ACLK);
      #1;
      if (!ARESET && RSP_VALID) begin
        rsp_valid_cycles++;
        if (RSP_READY) begin
          if (sb.size() == 0) check("rsp_unexpected", 1, 0);
          else begin
            e = sb.pop_front();
            check("rsp_write", RSP_WRITE, e.wr);
            check("rsp_data", RSP_DATA, e.data);
            check("rsp_status", RSP_STATUS, e.status);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int snap_rv, snap_aw;
    ARESET = 1; CMD_VALID = 0; CMD_WRITE = 0; CMD_ADDR = 0; CMD_WDATA = 0; CMD_WSTRB = 0;
    RSP_READY = 1;
    repeat (3) @(negedge ACLK);
    check("rst_flags", {AWVALID, WVALID, ARVALID, BREADY, RREADY, RSP_VALID, CMD_READY, BUSY},
          8'b0000_0010);
    check("rst_level", CMD_LEVEL, 0);
    check("rst_regs", {AWADDR, RSP_DATA, RSP_STATUS, RSP_WRITE}, 0);
    ARESET = 0;
    @(negedge ACLK);

    // Single write with first-VALID latency
    push_cmd(1, 32'hFFFF_0008, 32'h3000_0000, 4'hF, 0);
    check("lat_edge_n", AWVALID, 0);
    @(negedge ACLK);
    check("lat_edge_n1", AWVALID, 0);
    @(negedge ACLK);
    check("lat_edge_n2", {AWVALID, WVALID}, 2'b11);
    wait_idle("idle_write");

    // Single read with response back-pressure
    RSP_READY = 0;
    push_cmd(0, 32'hFFFF_0004, 32'h0, 4'h0, 0);
    t = 0;
    while (!RSP_VALID && t < 100) begin @(negedge ACLK); t++; end
    check("rd_rsp_valid", RSP_VALID, 1);
    check("rd_data", RSP_DATA, 32'h0000_00A5);
    check("rd_status", {RSP_WRITE, RSP_STATUS}, 4'b0000);
    repeat (3) @(negedge ACLK);
    check("rd_hold", {RSP_VALID, RSP_DATA}, {1'b1, 32'h0000_00A5});
    RSP_READY = 1;
    wait_idle("idle_read");

    // Skewed AW/W acceptance
    aw_cycles = 0; w_cycles = 0; b_hs = 0; aw_lat = 0; w_lat = 3;
    push_cmd(1, 32'h0000_0024, 32'hDEAD_BEEF, 4'h5, 0);
    wait_idle("idle_skew");
    check("skew_aw_cycles", aw_cycles, 1);
    check("skew_w_cycles", w_cycles, 4);
    check("skew_b_count", b_hs, 1);
    w_lat = 0;

    // FIFO fill while the slave stalls
    stall = 1;
    push_cmd(1, 32'h0000_0010, 32'h1111_2222, 4'h3, 0);
    push_cmd(0, 32'h0000_0024, 32'h0, 4'h0, 0);
    push_cmd(1, 32'h0000_0038, 32'h3333_4444, 4'hC, 0);
    push_cmd(0, 32'h0000_0014, 32'h0, 4'h0, 0);
    push_cmd(1, 32'h0000_0030, 32'h5555_6666, 4'h9, 0);
    check("full_level", CMD_LEVEL, 4);
    check("full_ready", {CMD_READY, BUSY}, 2'b01);
    stall = 0;
    wait_idle("idle_fifo");
    check("drained_level", {CMD_READY, CMD_LEVEL}, 4'b1000);

    // Read timeout followed by a normal write
    ar_stall = 1; ar_cycles = 0;
    push_cmd(0, 32'h0000_0020, 32'h0, 4'h0, 1);
    push_cmd(1, 32'h0000_0034, 32'h0BAD_F00D, 4'hC, 0);
    wait_idle("idle_timeout");
    check("to_ar_cycles", ar_cycles, 16);
    ar_stall = 0;

    // Asynchronous reset while waiting in RD
    RSP_READY = 0; r_hold = 1;
    push_cmd(0, 32'h0000_0028, 32'h0, 4'h0, 0);
    push_cmd(1, 32'h0000_0018, 32'h7777_8888, 4'hF, 0);
    t = 0;
    while (!RREADY && t < 100) begin @(negedge ACLK); t++; end
    check("pre_rst_rready", RREADY, 1);
    check("pre_rst_level", CMD_LEVEL, 1);
    snap_rv = rsp_valid_cycles; snap_aw = aw_hs;
    #2 ARESET = 1;
    #1;
    check("arst_flags", {AWVALID, WVALID, ARVALID, BREADY, RREADY, RSP_VALID, CMD_READY, BUSY},
          8'b0000_0010);
    check("arst_level", CMD_LEVEL, 0);
    check("arst_regs", {ARADDR, RSP_DATA, RSP_STATUS}, 0);
    sb.delete();
    wq.delete();
    repeat (2) @(negedge ACLK);
    ARESET = 0; r_hold = 0;
    repeat (20) @(negedge ACLK);
    check("no_rsp_after_rst", rsp_valid_cycles, snap_rv);
    check("flushed_no_aw", aw_hs, snap_aw);
    check("post_rst_idle", {BUSY, CMD_LEVEL}, 4'b0000);
    RSP_READY = 1;

    // Recovery transaction
    push_cmd(0, 32'h0000_003C, 32'h0, 4'h0, 0);
    wait_idle("idle_recover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
